char_buffer_ram: RTL and testbench
==================================

# char_buffer_ram

Writable, parametrised character buffer for the text overlay path: a COLS×ROWS array of character codes with a registered read port addressed by character coordinates and a valid/ready write port. It replaces fixed-content character ROMs feeding the glyph-lookup stage. It includes a clear engine that sweeps the array with spaces after reset and on request. An optional auto-incrementing write cursor is available.

## Interface
- COLS, default 16: characters per row, at least 2.
- ROWS, default 16: rows, at least 2.
- CHAR_W, default 7: character code width.
- XW, default $clog2(COLS): column index width (derived).
- YW, default $clog2(ROWS): row index width (derived).
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_x  in  XW  read column.
- rd_y  in  YW  read row.
- char_code  out  CHAR_W  registered read data.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_x  in  XW  write column.
- wr_y  in  YW  write row.
- wr_char  in  CHAR_W  write data.
- clr_req  in  1  single-cycle request to clear the array.
- busy  out  1  high while the clear engine runs.
- cur_x  out  XW  write cursor column; 0 when CHAR_BUF_AUTOINC_EN is undefined.
- cur_y  out  YW  write cursor row; 0 when CHAR_BUF_AUTOINC_EN is undefined.

## Operation
- Storage: COLS*ROWS entries of CHAR_W bits. Address = y*COLS + x. The array itself is not reset.
- Read: each cycle, char_code <= mem[rd_y*COLS+rd_x].
  - If rd_x >= COLS or rd_y >= ROWS, char_code <= 7'h20 (space, zero-extended to CHAR_W).
- FSM states: CLEAR, IDLE.
- Reset state: CLEAR, clear address 0, char_code = 0, busy = 1, cursor (0,0).
- CLEAR:
  - Writes 7'h20 to address clr_addr each cycle, then increments clr_addr.
  - After address COLS*ROWS-1 is written, goes to IDLE.
  - clr_req is ignored in this state.
  - wr_ready = 0.
- IDLE:
  - wr_ready = !clr_req (combinational).
  - On clr_req: go to CLEAR, clr_addr = 0, cursor = (0,0). A write offered in the same cycle is not accepted; clear wins.
  - On an accepted write: mem[wr_y*COLS+wr_x] <= wr_char.
  - If the write address is out of range, the write is dropped but the handshake still completes.
- busy = (state == CLEAR), registered.
- Simultaneous read and write to the same cell in one cycle: char_code returns the old content.

## Timing
- Read latency is 1 cycle.
- A write accepted at edge N is visible to a read addressed at edge N+1, with char_code valid after edge N+2.
- Clear takes exactly COLS*ROWS cycles in CLEAR.
- busy rises the cycle after clr_req and falls COLS*ROWS cycles later.
- After rst_n deasserts, wr_ready first rises after COLS*ROWS cycles.
- Reset mid-clear or mid-write: everything returns to the reset state immediately. Array contents are kept but undefined where the clear had not yet reached.

## Configuration
- CHAR_BUF_AUTOINC_EN defined:
  - wr_x and wr_y are ignored; writes go to the cursor position.
  - After each accepted write, cur_x increments; at COLS-1 it wraps to 0 and cur_y increments.
  - At (COLS-1, ROWS-1) the cursor wraps to (0,0).
  - The cursor is reset by rst_n and by any clear.
- CHAR_BUF_AUTOINC_EN undefined:
  - Writes use wr_x/wr_y.
  - cur_x and cur_y are tied to 0 and no cursor registers exist.

## Test plan
- Release reset, hold wr_valid=1 -> busy=1 and wr_ready=0 for 256 cycles (16×16); then a read of (3,5) returns 7'h20.
- IDLE, write 'A' (7'h41) at (15,15), read (15,15) the next cycle -> char_code = 7'h41 one cycle after the read address is applied; a read of (0,0) still gives 7'h20.
- Same-cycle write 'B' and read at (2,2) previously holding 'A' -> char_code = 'A'; the next read gives 'B'.
- clr_req and wr_valid asserted together in IDLE -> wr_ready=0, write not stored, busy high for 256 cycles, all cells read 7'h20.
- COLS=20, ROWS=12: write at (25,3) -> handshake completes, no cell changes; read at (25,3) returns 7'h20.
- CHAR_BUF_AUTOINC_EN defined: write 17 characters -> cursor at (1,1) and cell (0,1) holds the 17th character; 256 total writes wrap the cursor to (0,0).

Source files
------------

// File: rtl/char_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module   : char_buffer_ram
//  Purpose  : Writable COLS x ROWS character buffer for the text overlay path.
//             Registered read port addressed by character coordinates,
//             valid/ready write port, and a clear engine that fills the array
//             with spaces after reset and on request.
//  Options  : CHAR_BUF_AUTOINC_EN - writes go to an auto-incrementing cursor
//             instead of wr_x/wr_y.
//  Revision : 1.0 - initial release
// ============================================================================
module char_buffer_ram #(
  parameter int COLS   = 16,
  parameter int ROWS   = 16,
  parameter int CHAR_W = 7,
  parameter int XW     = $clog2(COLS),
  parameter int YW     = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XW-1:0]     rd_x,
  input  logic [YW-1:0]     rd_y,
  output logic [CHAR_W-1:0] char_code,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [XW-1:0]     wr_x,
  input  logic [YW-1:0]     wr_y,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              clr_req,
  output logic              busy,
  output logic [XW-1:0]     cur_x,
  output logic [YW-1:0]     cur_y
);

  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW-1:0]     LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0]     COLS_A    = AW'(COLS);
  localparam logic [XW:0]       COLS_X    = (XW + 1)'(COLS);
  localparam logic [YW:0]       ROWS_Y    = (YW + 1)'(ROWS);
  localparam logic [CHAR_W-1:0] SPACE     = CHAR_W'(7'h20);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Character storage; deliberately has no reset, the clear engine fills it
  logic [CHAR_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_addr_q, clr_addr_d;
  logic              busy_q, busy_d;
  logic [CHAR_W-1:0] char_code_q, char_code_d;

  // Single write port shared by the clear engine and the user write path
  logic              w_mem_we;
  logic [AW-1:0]     w_mem_addr;
  logic [CHAR_W-1:0] w_mem_data;

  logic              w_wr_fire;
  logic [XW-1:0]     w_wr_x;
  logic [YW-1:0]     w_wr_y;
  logic              w_wr_in_range;
  logic [AW-1:0]     w_wr_addr;
  logic              w_rd_in_range;
  logic [AW-1:0]     w_rd_addr;

  // Linear cell index; only meaningful when the coordinates are in range
  function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x,
                                               input logic [YW-1:0] y);
    return AW'(y) * COLS_A + AW'(x);
  endfunction

`ifdef CHAR_BUF_AUTOINC_EN
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  logic [XW-1:0] cur_x_q, cur_x_d;
  logic [YW-1:0] cur_y_q, cur_y_d;

  // Explicit coordinates are not used when the cursor drives writes
  logic unused_wr_xy;
  assign unused_wr_xy = ^{wr_x, wr_y};

  assign w_wr_x        = cur_x_q;
  assign w_wr_y        = cur_y_q;
  assign w_wr_in_range = 1'b1;
  assign cur_x         = cur_x_q;
  assign cur_y         = cur_y_q;

  // Cursor advance: row-major, wrapping at the last cell; any clear homes it
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (state_q == ST_CLEAR || clr_req) begin
      cur_x_d = '0;
      cur_y_d = '0;
    end else if (w_wr_fire) begin
      if (cur_x_q == X_LAST) begin
        cur_x_d = '0;
        cur_y_d = (cur_y_q == Y_LAST) ? '0 : cur_y_q + 1'b1;
      end else begin
        cur_x_d = cur_x_q + 1'b1;
      end
    end
  end

  // Cursor registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
    end else begin
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
    end
  end
`else
  assign w_wr_x        = wr_x;
  assign w_wr_y        = wr_y;
  assign w_wr_in_range = ({1'b0, wr_x} < COLS_X) && ({1'b0, wr_y} < ROWS_Y);
  assign cur_x         = '0;
  assign cur_y         = '0;
`endif

  assign w_wr_addr     = cell_addr(w_wr_x, w_wr_y);
  assign w_rd_addr     = cell_addr(rd_x, rd_y);
  assign w_rd_in_range = ({1'b0, rd_x} < COLS_X) && ({1'b0, rd_y} < ROWS_Y);

  // Next state, clear sweep and write handshake
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_ready   = 1'b0;
    w_wr_fire  = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_addr = '0;
    w_mem_data = SPACE;
    case (state_q)
      ST_CLEAR: begin
        // clr_req is ignored here; the sweep always runs to completion
        w_mem_we   = 1'b1;
        w_mem_addr = clr_addr_q;
        w_mem_data = SPACE;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        // A clear request blocks any write offered in the same cycle
        wr_ready = !clr_req;
        if (clr_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end else if (wr_valid) begin
          // Out-of-range writes still handshake but never touch the array
          w_wr_fire  = 1'b1;
          w_mem_we   = w_wr_in_range;
          w_mem_addr = w_wr_addr;
          w_mem_data = wr_char;
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_addr_d = '0;
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  // Read data: old cell content on a same-cycle write, space when off-grid
  always_comb begin
    char_code_d = SPACE;
    if (w_rd_in_range) begin
      char_code_d = mem[w_rd_addr];
    end
  end

  // Array write port
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem[w_mem_addr] <= w_mem_data;
    end
  end

  // Control and read-data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      busy_q      <= 1'b1;
      char_code_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      busy_q      <= busy_d;
      char_code_q <= char_code_d;
    end
  end

  assign busy      = busy_q;
  assign char_code = char_code_q;

endmodule
`default_nettype wire

// File: tb/tb_char_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_char_buffer_ram
//  Purpose  : Self-checking bench for char_buffer_ram: a 16x16 instance for
//             the main function and a 20x12 instance for off-grid addressing.
//             Also covers CHAR_BUF_AUTOINC_EN when that macro is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_char_buffer_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 16x16 instance
  logic [3:0] a_rd_x, a_rd_y, a_wr_x, a_wr_y, a_cur_x, a_cur_y;
  logic [6:0] a_char_code, a_wr_char;
  logic       a_wr_valid, a_wr_ready, a_clr_req, a_busy;

  // 20x12 instance
  logic [4:0] b_rd_x, b_wr_x, b_cur_x;
  logic [3:0] b_rd_y, b_wr_y, b_cur_y;
  logic [6:0] b_char_code, b_wr_char;
  logic       b_wr_valid, b_wr_ready, b_clr_req, b_busy;

  char_buffer_ram #(.COLS(16), .ROWS(16), .CHAR_W(7)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_x(a_rd_x), .rd_y(a_rd_y),
    .char_code(a_char_code), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
    .wr_x(a_wr_x), .wr_y(a_wr_y), .wr_char(a_wr_char), .clr_req(a_clr_req),
    .busy(a_busy), .cur_x(a_cur_x), .cur_y(a_cur_y)
  );

  char_buffer_ram #(.COLS(20), .ROWS(12), .CHAR_W(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_x(b_rd_x), .rd_y(b_rd_y),
    .char_code(b_char_code), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_x(b_wr_x), .wr_y(b_wr_y), .wr_char(b_wr_char), .clr_req(b_clr_req),
    .busy(b_busy), .cur_x(b_cur_x), .cur_y(b_cur_y)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected read data, pushed when the address is driven
  typedef struct {
    string      name;
    logic [6:0] exp;
  } sb_t;
  sb_t sbq[$];

  // One cycle of stimulus on the 16x16 instance and its expected read data
  typedef struct {
    logic       we;
    logic [3:0] wx;
    logic [3:0] wy;
    logic [6:0] wc;
    logic [3:0] rx;
    logic [3:0] ry;
    logic [6:0] exp;
    string      name;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input logic [6:0] act);
    sb_t s;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got data 0x%0h expected none", act);
    end else begin
      s = sbq.pop_front();
      check(s.name, {25'd0, act}, {25'd0, s.exp});
    end
  endtask

  task automatic a_read(input string name, input logic [3:0] x, input logic [3:0] y,
                        input logic [6:0] exp);
    @(negedge clk);
    a_rd_x = x;
    a_rd_y = y;
    sbq.push_back('{name: name, exp: exp});
    @(posedge clk);
    #1;
    sb_pop(a_char_code);
  endtask

  task automatic b_read(input string name, input logic [4:0] x, input logic [3:0] y,
                        input logic [6:0] exp);
    @(negedge clk);
    b_rd_x = x;
    b_rd_y = y;
    sbq.push_back('{name: name, exp: exp});
    @(posedge clk);
    #1;
    sb_pop(b_char_code);
  endtask

  // Called on a negedge; counts negedges until the 16x16 wr_ready rises,
  // noting when the 20x12 instance became ready and any busy dropout
  task automatic wait_ready(output int n, output int nb, output int busy_bad);
    nb       = -1;
    busy_bad = 0;
    for (n = 0; n < 1000; n++) begin
      if (b_wr_ready && nb < 0) nb = n;
      if (a_wr_ready) break;
      if (!a_busy) busy_bad++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, nb, busy_bad;

    vecs[0] = '{1'b1, 4'd15, 4'd15, 7'h41, 4'd0,  4'd0,  7'h20, "wrA_1515_rd00"};
    vecs[1] = '{1'b0, 4'd0,  4'd0,  7'h00, 4'd15, 4'd15, 7'h41, "rd_1515_A"};
    vecs[2] = '{1'b1, 4'd2,  4'd2,  7'h41, 4'd0,  4'd0,  7'h20, "wrA_22_rd00"};
    vecs[3] = '{1'b1, 4'd2,  4'd2,  7'h42, 4'd2,  4'd2,  7'h41, "wrB_rd22_old"};
    vecs[4] = '{1'b0, 4'd0,  4'd0,  7'h00, 4'd2,  4'd2,  7'h42, "rd_22_B"};
    vecs[5] = '{1'b1, 4'd0,  4'd15, 7'h7F, 4'd15, 4'd15, 7'h41, "wr7F_015"};
    vecs[6] = '{1'b1, 4'd15, 4'd0,  7'h00, 4'd0,  4'd15, 7'h7F, "rd_015_7F"};
    vecs[7] = '{1'b0, 4'd0,  4'd0,  7'h00, 4'd15, 4'd0,  7'h00, "rd_150_00"};
    vecs[8] = '{1'b0, 4'd0,  4'd0,  7'h00, 4'd3,  4'd5,  7'h20, "rd_35_space"};

    rst_n      = 1'b0;
    a_rd_x     = '0; a_rd_y = '0; a_wr_x = 4'd3; a_wr_y = 4'd5; a_wr_char = 7'h20;
    a_wr_valid = 1'b1; a_clr_req = 1'b0;
    b_rd_x     = '0; b_rd_y = '0; b_wr_x = '0; b_wr_y = '0; b_wr_char = '0;
    b_wr_valid = 1'b0; b_clr_req = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_char_code", {25'd0, a_char_code}, 32'h0);
    check("rst_busy", {31'd0, a_busy}, 32'd1);
    check("rst_wr_ready", {31'd0, a_wr_ready}, 32'd0);
    check("rst_cursor", {24'd0, a_cur_x, a_cur_y}, 32'd0);

    // Initial clear with wr_valid held high
    rst_n = 1'b1;
    wait_ready(n, nb, busy_bad);
    a_wr_valid = 1'b0;
    check("init_clear_cycles", n, 256);
    check("init_busy_dropout", busy_bad, 0);
    check("init_busy_after", {31'd0, a_busy}, 32'd0);
    check("b_init_clear_cycles", nb, 240);
    a_read("init_rd_35", 4'd3, 4'd5, 7'h20);

`ifndef CHAR_BUF_AUTOINC_EN
    // Table-driven read/write vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a_wr_valid = vecs[i].we;
      a_wr_x     = vecs[i].wx;
      a_wr_y     = vecs[i].wy;
      a_wr_char  = vecs[i].wc;
      a_rd_x     = vecs[i].rx;
      a_rd_y     = vecs[i].ry;
      if (vecs[i].we) check({"rdy_", vecs[i].name}, {31'd0, a_wr_ready}, 32'd1);
      sbq.push_back('{name: vecs[i].name, exp: vecs[i].exp});
      @(posedge clk);
      #1;
      sb_pop(a_char_code);
    end
    check("no_cursor", {24'd0, a_cur_x, a_cur_y}, 32'd0);
`endif

    // Clear requested together with a write: clear wins
    @(negedge clk);
    a_clr_req  = 1'b1;
    a_wr_valid = 1'b1;
    a_wr_x     = 4'd1;
    a_wr_y     = 4'd1;
    a_wr_char  = 7'h5A;
    #1;
    check("clr_blocks_ready", {31'd0, a_wr_ready}, 32'd0);
    @(negedge clk);
    a_clr_req  = 1'b0;
    a_wr_valid = 1'b0;
    busy_bad   = 0;
    for (n = 0; n < 1000; n++) begin
      if (!a_busy) break;
      if (a_wr_ready) busy_bad++;
      @(negedge clk);
    end
    check("clr_busy_cycles", n, 256);
    check("clr_ready_while_busy", busy_bad, 0);
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        a_read($sformatf("clr_cell_%0d_%0d", x, y), 4'(x), 4'(y), 7'h20);
      end
    end

`ifdef CHAR_BUF_AUTOINC_EN
    // Cursor-driven writes
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      a_wr_valid = 1'b1;
      a_wr_char  = 7'(8'h30 + i);
      @(posedge clk);
    end
    @(negedge clk);
    a_wr_valid = 1'b0;
    check("cursor_after_17", {24'd0, a_cur_x, a_cur_y}, {24'd0, 4'd1, 4'd1});
    a_read("auto_cell_01", 4'd0, 4'd1, 7'h40);
    a_read("auto_cell_150", 4'd15, 4'd0, 7'h3F);
    for (int i = 0; i < 239; i++) begin
      @(negedge clk);
      a_wr_valid = 1'b1;
      a_wr_char  = 7'h61;
      @(posedge clk);
    end
    @(negedge clk);
    a_wr_valid = 1'b0;
    check("cursor_wrap_256", {24'd0, a_cur_x, a_cur_y}, 32'd0);
`else
    // Off-grid write and reads on the 20x12 instance
    @(negedge clk);
    b_wr_valid = 1'b1;
    b_wr_x     = 5'd25;
    b_wr_y     = 4'd3;
    b_wr_char  = 7'h41;
    check("b_oob_ready", {31'd0, b_wr_ready}, 32'd1);
    @(negedge clk);
    b_wr_valid = 1'b0;
    b_read("b_rd_25_3", 5'd25, 4'd3, 7'h20);
    b_read("b_alias_5_4", 5'd5, 4'd4, 7'h20);
    b_read("b_rd_0_13", 5'd0, 4'd13, 7'h20);
    @(negedge clk);
    b_wr_valid = 1'b1;
    b_wr_x     = 5'd19;
    b_wr_y     = 4'd11;
    b_wr_char  = 7'h43;
    @(negedge clk);
    b_wr_valid = 1'b0;
    b_read("b_rd_19_11", 5'd19, 4'd11, 7'h43);
`endif

    // Reset in the middle of a write
    @(negedge clk);
    a_wr_valid = 1'b1;
    a_wr_x     = 4'd4;
    a_wr_y     = 4'd4;
    a_wr_char  = 7'h51;
    rst_n      = 1'b0;
    #1;
    check("midrst_char_code", {25'd0, a_char_code}, 32'h0);
    check("midrst_busy", {31'd0, a_busy}, 32'd1);
    check("midrst_wr_ready", {31'd0, a_wr_ready}, 32'd0);
    @(negedge clk);
    a_wr_valid = 1'b0;
    rst_n      = 1'b1;
    wait_ready(n, nb, busy_bad);
    check("midrst_clear_cycles", n, 256);
    a_read("midrst_cell_44", 4'd4, 4'd4, 7'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
